// File: rtl/uart_tx_if.sv
// Parallel-to-serial request bus for uart_tx: a byte plus framing config in,
// serial line and busy flag out.
interface uart_tx_if #(
   parameter int WIDTH = 8
);
   // Data_Valid is a request with no ready: it is taken only on a cycle where
   // the transmitter is idle (busy low); requests raised while busy are dropped.
   logic [WIDTH-1:0] P_DATA;
   logic             Data_Valid;
   logic             PAR_EN;
   logic             PAR_TYP;
   logic [4:0]       Prescale;
   logic             TX_OUT;
   logic             busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      output TX_OUT, busy
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity,
// one stop bit; every bit lasts Prescale clock cycles (0 counts as 1).
module uart_tx #(
   parameter int WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   uart_tx_if.slave   tx_if,
   output logic [2:0] dbg_state
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [4:0]       edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             par_en_q, par_en_d;
   logic             par_typ_q, par_typ_d;
   logic [4:0]       prescale_q, prescale_d;
   logic             tx_out_q, tx_out_d;
   logic             busy_q, busy_d;

   logic [4:0]       edge_last;
   logic             bit_done;
   logic [CNT_W-1:0] bit_nxt;
   logic             parity_bit;

   // A latched prescale of zero behaves as one cycle per bit.
   assign edge_last  = (prescale_q == 5'd0) ? 5'd0 : prescale_q - 5'd1;
   assign bit_done   = (edge_cnt_q == edge_last);
   assign bit_nxt    = bit_cnt_q + CNT_W'(1);
   assign parity_bit = (^data_q) ^ par_typ_q;

   always_comb begin
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      prescale_d = prescale_q;
      tx_out_d   = tx_out_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            edge_cnt_d = 5'd0;
            bit_cnt_d  = '0;
            tx_out_d   = 1'b1;
            busy_d     = 1'b0;
            if (tx_if.Data_Valid) begin
               state_d    = START;
               data_d     = tx_if.P_DATA;
               par_en_d   = tx_if.PAR_EN;
               par_typ_d  = tx_if.PAR_TYP;
               prescale_d = tx_if.Prescale;
               tx_out_d   = 1'b0;
               busy_d     = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               edge_cnt_d = 5'd0;
               state_d    = DATA;
               tx_out_d   = data_q[0];
            end else begin
               edge_cnt_d = edge_cnt_q + 5'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               edge_cnt_d = 5'd0;
               if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
                  tx_out_d  = par_en_q ? parity_bit : 1'b1;
               end else begin
                  bit_cnt_d = bit_nxt;
                  tx_out_d  = data_q[bit_nxt];
               end
            end else begin
               edge_cnt_d = edge_cnt_q + 5'd1;
            end
         end
         PARITY: begin
            if (bit_done) begin
               edge_cnt_d = 5'd0;
               state_d    = STOP;
               tx_out_d   = 1'b1;
            end else begin
               edge_cnt_d = edge_cnt_q + 5'd1;
            end
         end
         STOP: begin
            // Dropping busy here makes the next cycle the single idle-high cycle.
            if (bit_done) begin
               edge_cnt_d = 5'd0;
               state_d    = IDLE;
               tx_out_d   = 1'b1;
               busy_d     = 1'b0;
            end else begin
               edge_cnt_d = edge_cnt_q + 5'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         edge_cnt_q <= 5'd0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         prescale_q <= 5'd0;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         prescale_q <= prescale_d;
         tx_out_q   <= tx_out_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_if.TX_OUT = tx_out_q;
   assign tx_if.busy   = busy_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model predicts the serial line
// and busy flag cycle by cycle; scenario tasks compare against it.
module tb_uart_tx;
   localparam int WIDTH = 8;

   logic       CLK;
   logic       RST;
   logic [2:0] dbg_state;

   uart_tx_if #(.WIDTH(WIDTH)) u_if();

   uart_tx #(.WIDTH(WIDTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .tx_if     (u_if),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // reference model: on an accept the whole frame is expanded into a queue
   // of line levels, one entry per clock cycle
   logic       exp_tx   = 1'b1;
   logic       exp_busy = 1'b0;
   logic [0:0] exp_q[$];
   int         m_pre;
   logic       m_par;

   always @(posedge CLK) begin
      if (RST) begin
         exp_q.delete();
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
      end else begin
         if (!exp_busy && u_if.Data_Valid) begin
            m_pre = (u_if.Prescale == 5'd0) ? 1 : int'(u_if.Prescale);
            m_par = (^u_if.P_DATA) ^ u_if.PAR_TYP;
            for (int r = 0; r < m_pre; r++) exp_q.push_back(1'b0);
            for (int i = 0; i < WIDTH; i++)
               for (int r = 0; r < m_pre; r++) exp_q.push_back(u_if.P_DATA[i]);
            if (u_if.PAR_EN)
               for (int r = 0; r < m_pre; r++) exp_q.push_back(m_par);
            for (int r = 0; r < m_pre; r++) exp_q.push_back(1'b1);
         end
         if (exp_q.size() > 0) begin
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
         end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic drive_cfg(input logic [WIDTH-1:0] d, input logic pe,
                            input logic pt, input logic [4:0] pre);
      u_if.P_DATA   = d;
      u_if.PAR_EN   = pe;
      u_if.PAR_TYP  = pt;
      u_if.Prescale = pre;
   endtask

   task automatic scramble_cfg();
      u_if.P_DATA   = WIDTH'($urandom);
      u_if.PAR_EN   = 1'($urandom_range(0, 1));
      u_if.PAR_TYP  = 1'($urandom_range(0, 1));
      u_if.Prescale = 5'($urandom_range(0, 31));
   endtask

   task automatic test_reset();
      RST = 1'b1;
      u_if.Data_Valid = 1'b1;
      drive_cfg(8'h5A, 1'b1, 1'b0, 5'd3);
      repeat (3) begin
         @(negedge CLK);
         checks++;
         if (u_if.TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", u_if.TX_OUT);
         end
         checks++;
         if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", u_if.busy);
         end
      end
      RST = 1'b0;
      u_if.Data_Valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: tx/busy got %b/%b expected 1/0", u_if.TX_OUT, u_if.busy);
      end
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] t_data[4] = '{8'hA5, 8'hA5, 8'h00, 8'hFF};
      logic             t_pe[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic             t_pt[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [4:0]       t_pre[4]  = '{5'd8, 5'd16, 5'd4, 5'd0};
      int               t_len[4]  = '{88, 176, 40, 10};
      int               busy_len;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         drive_cfg(t_data[k], t_pe[k], t_pt[k], t_pre[k]);
         u_if.Data_Valid = 1'b1;
         @(negedge CLK);
         u_if.Data_Valid = 1'b0;
         scramble_cfg();
         busy_len = 0;
         for (int c = 0; c < 600; c++) begin
            checks++;
            if (u_if.TX_OUT !== exp_tx || u_if.busy !== exp_busy) begin
               errors++;
               $display("FAIL directed%0d cyc %0d: tx/busy got %b/%b expected %b/%b",
                        k, c, u_if.TX_OUT, u_if.busy, exp_tx, exp_busy);
            end
            if (u_if.busy !== 1'b1) break;
            busy_len++;
            @(negedge CLK);
         end
         checks++;
         if (busy_len != t_len[k]) begin
            errors++;
            $display("FAIL directed%0d_busy_len: got %0d expected %0d", k, busy_len, t_len[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int stage = 0;
      int len1 = 0;
      int gap = 0;
      int len2 = 0;
      @(negedge CLK);
      drive_cfg(8'h3C, 1'b1, 1'b0, 5'd3);
      u_if.Data_Valid = 1'b1;
      @(negedge CLK);
      u_if.P_DATA = 8'hC3;
      for (int c = 0; c < 400; c++) begin
         checks++;
         if (u_if.TX_OUT !== exp_tx || u_if.busy !== exp_busy) begin
            errors++;
            $display("FAIL b2b cyc %0d: tx/busy got %b/%b expected %b/%b",
                     c, u_if.TX_OUT, u_if.busy, exp_tx, exp_busy);
         end
         if (stage == 0) begin
            if (u_if.busy === 1'b1) len1++;
            else begin stage = 1; gap++; end
         end else if (stage == 1) begin
            if (u_if.busy === 1'b1) begin stage = 2; len2++; end
            else gap++;
         end else begin
            if (u_if.busy !== 1'b1) break;
            len2++;
         end
         // once frame 2 runs, random pulses must be ignored
         if (stage == 2) begin
            u_if.Data_Valid = 1'($urandom_range(0, 1));
            u_if.P_DATA     = WIDTH'($urandom);
         end
         @(negedge CLK);
      end
      u_if.Data_Valid = 1'b0;
      checks++;
      if (gap != 1) begin
         errors++;
         $display("FAIL b2b_gap: got %0d idle cycles expected 1", gap);
      end
      checks++;
      if (len1 != 33 || len2 != 33) begin
         errors++;
         $display("FAIL b2b_len: got %0d/%0d expected 33/33", len1, len2);
      end
      repeat (2) begin
         @(negedge CLK);
         checks++;
         if (u_if.busy !== 1'b0 || u_if.TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_queue: tx/busy got %b/%b expected 1/0", u_if.TX_OUT, u_if.busy);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int busy_len = 0;
      @(negedge CLK);
      drive_cfg(8'h5A, 1'b1, 1'b0, 5'd4);
      u_if.Data_Valid = 1'b1;
      @(negedge CLK);
      u_if.Data_Valid = 1'b0;
      // start bit plus three data bits, then two cycles into bit 3
      for (int c = 0; c < 18; c++) begin
         checks++;
         if (u_if.TX_OUT !== exp_tx || u_if.busy !== exp_busy) begin
            errors++;
            $display("FAIL rstmid_pre cyc %0d: tx/busy got %b/%b expected %b/%b",
                     c, u_if.TX_OUT, u_if.busy, exp_tx, exp_busy);
         end
         @(negedge CLK);
      end
      RST = 1'b1;
      u_if.Data_Valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         checks++;
         if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort cyc %0d: tx/busy got %b/%b expected 1/0",
                     c, u_if.TX_OUT, u_if.busy);
         end
      end
      RST = 1'b0;
      drive_cfg(8'h81, 1'b0, 1'b0, 5'd2);
      @(negedge CLK);
      u_if.Data_Valid = 1'b0;
      checks++;
      if (u_if.TX_OUT !== 1'b0 || u_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_first_accept: tx/busy got %b/%b expected 0/1", u_if.TX_OUT, u_if.busy);
      end
      for (int c = 0; c < 100; c++) begin
         checks++;
         if (u_if.TX_OUT !== exp_tx || u_if.busy !== exp_busy) begin
            errors++;
            $display("FAIL rstmid_post cyc %0d: tx/busy got %b/%b expected %b/%b",
                     c, u_if.TX_OUT, u_if.busy, exp_tx, exp_busy);
         end
         if (u_if.busy !== 1'b1) break;
         busy_len++;
         @(negedge CLK);
      end
      checks++;
      if (busy_len != 20) begin
         errors++;
         $display("FAIL rstmid_busy_len: got %0d expected 20", busy_len);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] d;
      logic             pe, pt;
      logic [4:0]       pre;
      int               busy_len, exp_len;
      for (int n = 0; n < 20; n++) begin
         d   = WIDTH'($urandom);
         pe  = 1'($urandom_range(0, 1));
         pt  = 1'($urandom_range(0, 1));
         pre = 5'($urandom_range(0, 7));
         exp_len = (WIDTH + 2 + int'(pe)) * ((pre == 5'd0) ? 1 : int'(pre));
         repeat ($urandom_range(1, 3)) @(negedge CLK);
         drive_cfg(d, pe, pt, pre);
         u_if.Data_Valid = 1'b1;
         @(negedge CLK);
         u_if.Data_Valid = 1'b0;
         busy_len = 0;
         for (int c = 0; c < 400; c++) begin
            checks++;
            if (u_if.TX_OUT !== exp_tx || u_if.busy !== exp_busy) begin
               errors++;
               $display("FAIL random%0d cyc %0d: tx/busy got %b/%b expected %b/%b",
                        n, c, u_if.TX_OUT, u_if.busy, exp_tx, exp_busy);
            end
            if (u_if.busy !== 1'b1) break;
            busy_len++;
            u_if.Data_Valid = 1'($urandom_range(0, 1));
            scramble_cfg();
            @(negedge CLK);
         end
         u_if.Data_Valid = 1'b0;
         checks++;
         if (busy_len != exp_len) begin
            errors++;
            $display("FAIL random%0d_busy_len: got %0d expected %0d", n, busy_len, exp_len);
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      u_if.Data_Valid = 1'b0;
      drive_cfg('0, 1'b0, 1'b0, 5'd0);
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
